// File: rtl/fm_cordic_pkg.sv
// Shared widths, encodings and reset constants for the FM CORDIC phase scheduler.
// Also holds the phase-fold and message-deviation helpers used at issue time.
package fm_cordic_pkg;

    localparam int PHASE_W    = 32;
    localparam int MSG_W      = 16;
    localparam int DIV_W      = 16;
    localparam int SHIFT_W    = 5;
    localparam int PIPE_DEPTH = 15;

    typedef enum logic [1:0] {
        QUAD_0 = 2'b00,
        QUAD_1 = 2'b01,
        QUAD_2 = 2'b10,
        QUAD_3 = 2'b11
    } quad_e;

    typedef enum logic [1:0] {
        VSEL_POS_X = 2'b00,
        VSEL_POS_Y = 2'b01,
        VSEL_NEG_Y = 2'b10
    } vsel_e;

    typedef struct packed {
        logic [PHASE_W-1:0] carrier_inc;
        logic [SHIFT_W-1:0] dev_shift;
        logic [DIV_W-1:0]   div;
    } cfg_t;

    typedef struct packed {
        logic [PHASE_W-1:0] z;
        vsel_e              vsel;
        quad_e              quad;
    } fold_t;

    localparam logic [PHASE_W-1:0] RESET_CARRIER_INC = 32'h00B6_1000;
    localparam logic [DIV_W-1:0]   RESET_DIV         = 16'd2047;
    localparam cfg_t RESET_CFG = '{
        carrier_inc: RESET_CARRIER_INC,
        dev_shift:   '0,
        div:         RESET_DIV
    };

    // Quadrants 1 and 2 are rotated by -/+90 degrees by keeping the low bits and
    // starting the CORDIC from (0,K) or (0,-K) instead of (K,0).
    function automatic fold_t foldPhase(input logic [PHASE_W-1:0] theta);
        fold_t f;
        f.quad = quad_e'(theta[PHASE_W-1 -: 2]);
        f.z    = theta;
        f.vsel = VSEL_POS_X;
        case (f.quad)
            QUAD_1: begin
                f.z    = {2'b00, theta[PHASE_W-3:0]};
                f.vsel = VSEL_POS_Y;
            end
            QUAD_2: begin
                f.z    = {2'b11, theta[PHASE_W-3:0]};
                f.vsel = VSEL_NEG_Y;
            end
            default: ;
        endcase
        return f;
    endfunction

    function automatic logic [PHASE_W-1:0] msgDeviation(
        input logic [MSG_W-1:0]   msg,
        input logic [SHIFT_W-1:0] shift
    );
        logic [PHASE_W-1:0] ext;
        ext = {{(PHASE_W-MSG_W){msg[MSG_W-1]}}, msg};
        return ext << shift;
    endfunction

endpackage

// File: rtl/fm_sample_timer.sv
// Sample divider: counts 0..div and strobes on the terminal count while enabled.
// The count is parked at zero while disabled or when the divider setting changes.
module fm_sample_timer
    import fm_cordic_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             strobe_o
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    assign strobe_o = enable_i && !reset && (count_q == div_i);

    always_comb begin
        count_d = count_q + DIV_W'(1);
        if (!enable_i || restart_i || strobe_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fm_phase_scheduler.sv
// FM modulator phase scheduler: sample strobe, phase accumulator with message
// deviation, quadrant folding for the CORDIC input and per-result quadrant tracking.
module fm_phase_scheduler
    import fm_cordic_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_carrier_inc,
    input  logic [SHIFT_W-1:0] cfg_dev_shift,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [MSG_W-1:0]   msg_data,
    output logic               cordic_start,
    output logic [PHASE_W-1:0] cordic_z,
    output logic [1:0]         cordic_vsel,
    output logic               out_valid,
    output logic [1:0]         out_quad,
    output logic               msg_underrun
);

    cfg_t                          activeCfg_q, activeCfg_d;
    cfg_t                          pendCfg_q, pendCfg_d;
    logic                          pendValid_q, pendValid_d;
    logic [PHASE_W-1:0]            theta_q, theta_d;
    logic [MSG_W-1:0]              msgHold_q, msgHold_d;
    logic [PHASE_W-1:0]            issueZ_q, issueZ_d;
    vsel_e                         issueVsel_q, issueVsel_d;
    logic [PIPE_DEPTH-1:0]         trackValid_q, trackValid_d;
    logic [PIPE_DEPTH-1:0][1:0]    trackQuad_q, trackQuad_d;
    logic                          shifted_q;

    logic                          strobe;
    logic                          applyCfg;
    logic                          restartTimer;
    logic [MSG_W-1:0]              msgSel;
    fold_t                         issue;

    // A pending config lands on a strobe edge, or straight away when stopped.
    assign applyCfg     = pendValid_q && (strobe || !enable);
    assign restartTimer = applyCfg && (pendCfg_q.div != activeCfg_q.div);

    fm_sample_timer u_timer (
        .clock     (clock),
        .reset     (reset),
        .enable_i  (enable),
        .restart_i (restartTimer),
        .div_i     (activeCfg_q.div),
        .strobe_o  (strobe)
    );

    assign msgSel = msg_valid ? msg_data : msgHold_q;
    assign issue  = foldPhase(theta_q);

    assign cfg_ready    = !pendValid_q;
    assign cordic_start = strobe;
    assign msg_ready    = strobe;
    assign msg_underrun = strobe && !msg_valid;
    assign cordic_z     = issueZ_q;
    assign cordic_vsel  = issueVsel_q;
    assign out_valid    = shifted_q && trackValid_q[PIPE_DEPTH-1];
    assign out_quad     = trackQuad_q[PIPE_DEPTH-1];

    always_comb begin
        activeCfg_d = activeCfg_q;
        pendCfg_d   = pendCfg_q;
        pendValid_d = pendValid_q;
        if (applyCfg) begin
            activeCfg_d = pendCfg_q;
            pendValid_d = 1'b0;
        end else if (cfg_valid && cfg_ready) begin
            pendCfg_d = '{
                carrier_inc: cfg_carrier_inc,
                dev_shift:   cfg_dev_shift,
                div:         cfg_div
            };
            pendValid_d = 1'b1;
        end
    end

    // Issue uses the pre-update phase; the accumulator and tracking advance together.
    always_comb begin
        theta_d      = theta_q;
        msgHold_d    = msgHold_q;
        issueZ_d     = issueZ_q;
        issueVsel_d  = issueVsel_q;
        trackValid_d = trackValid_q;
        trackQuad_d  = trackQuad_q;
        if (strobe) begin
            msgHold_d    = msgSel;
            theta_d      = theta_q + activeCfg_q.carrier_inc
                         + msgDeviation(msgSel, activeCfg_q.dev_shift);
            issueZ_d     = issue.z;
            issueVsel_d  = issue.vsel;
            trackValid_d = {trackValid_q[PIPE_DEPTH-2:0], 1'b1};
            trackQuad_d  = {trackQuad_q[PIPE_DEPTH-2:0], issue.quad};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            activeCfg_q  <= RESET_CFG;
            pendCfg_q    <= '0;
            pendValid_q  <= 1'b0;
            theta_q      <= '0;
            msgHold_q    <= '0;
            issueZ_q     <= '0;
            issueVsel_q  <= VSEL_POS_X;
            trackValid_q <= '0;
            trackQuad_q  <= '0;
            shifted_q    <= 1'b0;
        end else begin
            activeCfg_q  <= activeCfg_d;
            pendCfg_q    <= pendCfg_d;
            pendValid_q  <= pendValid_d;
            theta_q      <= theta_d;
            msgHold_q    <= msgHold_d;
            issueZ_q     <= issueZ_d;
            issueVsel_q  <= issueVsel_d;
            trackValid_q <= trackValid_d;
            trackQuad_q  <= trackQuad_d;
            shifted_q    <= strobe;
        end
    end

endmodule

// File: tb/tb_fm_phase_scheduler.sv
// Directed bench for fm_phase_scheduler: hand-computed phase, fold, tracking
// and configuration-timing expectations checked with immediate assertions.
module tb_fm_phase_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_carrier_inc = '0;
    logic [4:0]  cfg_dev_shift = '0;
    logic [15:0] cfg_div = '0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [15:0] msg_data = '0;
    logic        cordic_start;
    logic [31:0] cordic_z;
    logic [1:0]  cordic_vsel;
    logic        out_valid;
    logic [1:0]  out_quad;
    logic        msg_underrun;

    int vectors = 0;
    int miscompares = 0;
    int w;

    logic [31:0] t1Z [4] = '{32'h0000_0000, 32'h0000_0000, 32'hC000_0000, 32'hC000_0000};
    logic [31:0] t1V [4] = '{32'd0, 32'd1, 32'd2, 32'd0};
    logic [31:0] t1W [4] = '{32'd3, 32'd4, 32'd4, 32'd4};
    logic [31:0] t2Z [7] = '{32'h000, 32'h110, 32'h220, 32'h330, 32'h420, 32'h510, 32'h600};
    logic [31:0] t2U [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};

    always #5 clock = ~clock;

    fm_phase_scheduler dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_carrier_inc (cfg_carrier_inc),
        .cfg_dev_shift   (cfg_dev_shift),
        .cfg_div         (cfg_div),
        .msg_valid       (msg_valid),
        .msg_ready       (msg_ready),
        .msg_data        (msg_data),
        .cordic_start    (cordic_start),
        .cordic_z        (cordic_z),
        .cordic_vsel     (cordic_vsel),
        .out_valid       (out_valid),
        .out_quad        (out_quad),
        .msg_underrun    (msg_underrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        msg_valid = 1'b0;
        msg_data  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Configuration handshake; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic [31:0] inc, input logic [4:0] shift,
                                 input logic [15:0] div);
        int n;
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        cfg_valid       = 1'b1;
        cfg_carrier_inc = inc;
        cfg_dev_shift   = shift;
        cfg_div         = div;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic waitStrobe(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!cordic_start && waited < budget);
        checkOutput("strobe_seen", 32'(cordic_start), 32'd1);
    endtask

    task automatic issueEdge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_start", 32'(cordic_start), 32'd0);
        checkOutput("rst_msg_ready", 32'(msg_ready), 32'd0);
        checkOutput("rst_z", cordic_z, 32'd0);
        checkOutput("rst_vsel", 32'(cordic_vsel), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_quad", 32'(out_quad), 32'd0);
        checkOutput("rst_underrun", 32'(msg_underrun), 32'd0);

        // Quadrant walk at div=3 with no message
        applyStimulus(32'h4000_0000, 5'd0, 16'd3);
        checkOutput("t1_cfg_ready_pending", 32'(cfg_ready), 32'd0);
        @(negedge clock);
        checkOutput("t1_cfg_ready_applied", 32'(cfg_ready), 32'd1);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitStrobe(20, w);
            checkOutput($sformatf("t1_interval%0d", i), w, t1W[i]);
            checkOutput($sformatf("t1_underrun%0d", i), 32'(msg_underrun), 32'd1);
            issueEdge();
            checkOutput($sformatf("t1_z%0d", i), cordic_z, t1Z[i]);
            checkOutput($sformatf("t1_vsel%0d", i), 32'(cordic_vsel), t1V[i]);
        end

        // Message deviation +1/-1 with dev_shift=4, then reuse on underrun
        doReset();
        applyStimulus(32'h0000_0100, 5'd4, 16'd3);
        @(negedge clock);
        msg_valid = 1'b1;
        msg_data  = 16'h0001;
        enable    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) msg_data = 16'hFFFF;
            if (i == 5) msg_valid = 1'b0;
            waitStrobe(20, w);
            if (i == 0) checkOutput("t2_msg_ready", 32'(msg_ready), 32'd1);
            checkOutput($sformatf("t2_underrun%0d", i), 32'(msg_underrun), t2U[i]);
            issueEdge();
            checkOutput($sformatf("t2_z%0d", i), cordic_z, t2Z[i]);
        end

        // Phase wrap 0xFFFF_FF00 -> 0x100 with a config queued while running
        doReset();
        applyStimulus(32'hFFFF_FF00, 5'd0, 16'd3);
        @(negedge clock);
        enable = 1'b1;
        applyStimulus(32'h0000_0200, 5'd0, 16'd3);
        checkOutput("t3_cfg_ready_low", 32'(cfg_ready), 32'd0);
        waitStrobe(20, w);
        checkOutput("t3_cfg_ready_hold", 32'(cfg_ready), 32'd0);
        issueEdge();
        checkOutput("t3_cfg_ready_applied", 32'(cfg_ready), 32'd1);
        checkOutput("t3_z0", cordic_z, 32'h0000_0000);
        waitStrobe(20, w);
        issueEdge();
        checkOutput("t3_z1", cordic_z, 32'hFFFF_FF00);
        checkOutput("t3_vsel1", 32'(cordic_vsel), 32'd0);
        waitStrobe(20, w);
        issueEdge();
        checkOutput("t3_z2", cordic_z, 32'h0000_0100);
        checkOutput("t3_vsel2", 32'(cordic_vsel), 32'd0);
        waitStrobe(20, w);
        issueEdge();
        checkOutput("t3_z3", cordic_z, 32'h0000_0300);

        // Config handshake in a strobe cycle: old increment for two more updates
        doReset();
        applyStimulus(32'h0000_1000, 5'd0, 16'd3);
        @(negedge clock);
        enable = 1'b1;
        waitStrobe(20, w);
        cfg_valid       = 1'b1;
        cfg_carrier_inc = 32'h0000_3000;
        cfg_dev_shift   = 5'd0;
        cfg_div         = 16'd3;
        issueEdge();
        cfg_valid = 1'b0;
        checkOutput("t5_cfg_ready_low", 32'(cfg_ready), 32'd0);
        checkOutput("t5_z0", cordic_z, 32'h0000_0000);
        waitStrobe(20, w);
        checkOutput("t5_interval", w, 32'd4);
        issueEdge();
        checkOutput("t5_cfg_ready_applied", 32'(cfg_ready), 32'd1);
        checkOutput("t5_z1", cordic_z, 32'h0000_1000);
        waitStrobe(20, w);
        issueEdge();
        checkOutput("t5_z2", cordic_z, 32'h0000_2000);
        waitStrobe(20, w);
        issueEdge();
        checkOutput("t5_z3", cordic_z, 32'h0000_5000);
        waitStrobe(20, w);
        issueEdge();
        checkOutput("t5_z4", cordic_z, 32'h0000_8000);

        // Pipeline tracking: 20 strobes at div=0
        doReset();
        applyStimulus(32'h4000_0000, 5'd0, 16'd0);
        @(negedge clock);
        enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            issueEdge();
            checkOutput($sformatf("t4_valid%0d", i), 32'(out_valid),
                        (i >= 15 && i <= 20) ? 32'd1 : 32'd0);
            if (i >= 15 && i <= 20)
                checkOutput($sformatf("t4_quad%0d", i), 32'(out_quad), 32'((i - 15) % 4));
            if (i == 25) checkOutput("t4_quad_held", 32'(out_quad), 32'd1);
            if (i == 20) enable = 1'b0;
        end

        // Enable drop with 7 in flight
        doReset();
        applyStimulus(32'h4000_0000, 5'd0, 16'd0);
        @(negedge clock);
        enable = 1'b1;
        repeat (7) issueEdge();
        enable = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            issueEdge();
            checkOutput("t6_idle_valid", 32'(out_valid), 32'd0);
            if (i == 10) checkOutput("t6_idle_start", 32'(cordic_start), 32'd0);
        end
        enable = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            issueEdge();
            checkOutput($sformatf("t6_valid%0d", j), 32'(out_valid),
                        (j >= 8) ? 32'd1 : 32'd0);
            if (j >= 8)
                checkOutput($sformatf("t6_quad%0d", j), 32'(out_quad), 32'((j - 8) % 4));
        end

        // Reset discards a pending config; reset divider and increment take effect
        doReset();
        enable = 1'b1;
        applyStimulus(32'h0000_1234, 5'd0, 16'd5);
        checkOutput("t7_pending", 32'(cfg_ready), 32'd0);
        doReset();
        checkOutput("t7_discarded", 32'(cfg_ready), 32'd1);
        enable = 1'b1;
        waitStrobe(3000, w);
        checkOutput("t7_first_strobe", w, 32'd2047);
        issueEdge();
        checkOutput("t7_z0", cordic_z, 32'h0000_0000);
        waitStrobe(3000, w);
        checkOutput("t7_interval", w, 32'd2048);
        issueEdge();
        checkOutput("t7_z1", cordic_z, 32'h00B6_1000);
        checkOutput("t7_vsel1", 32'(cordic_vsel), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
